// File: rtl/l3_arb_pkg.sv
// Shared types and sizing helpers for the L3 port arbiter.
// IDX_WIDTH/WDOG_WIDTH describe the default configuration; modules re-derive widths from their own parameters.
package l3_arb_pkg;

  localparam int DEF_NUM_REQ        = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int IDX_WIDTH          = $clog2(DEF_NUM_REQ);
  localparam int WDOG_WIDTH         = $clog2(DEF_TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // $clog2 returns 0 for 1, which would collapse a vector to zero width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/l3_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_i+1, wrapping.
module rr_pick
  import l3_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = IDX_WIDTH
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   idx_o
);

  int                 cand;
  logic [IDX_W-1:0]   candIdx;

  always_comb begin
    valid_o = 1'b0;
    pick_o  = '0;
    idx_o   = '0;
    cand    = 0;
    candIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand    = (int'(last_i) + 1 + k) % NUM_REQ;
      candIdx = IDX_W'(cand);
      if (!valid_o && req_i[candIdx]) begin
        valid_o         = 1'b1;
        pick_o[candIdx] = 1'b1;
        idx_o           = candIdx;
      end
    end
  end

endmodule

// File: rtl/l3_port_arbiter.sv
// Shares one single-word L3 access port between NUM_REQ requesters, round-robin,
// with a watchdog that aborts transactions the L3 never completes.
module l3_port_arbiter
  import l3_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_address_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data_i,
  input  logic [NUM_REQ-1:0]            req_write_enable_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          busy_o,
  output logic                          l3_valid_o,
  output logic [DATA_WIDTH-1:0]         l3_address_o,
  output logic [DATA_WIDTH-1:0]         l3_write_data_o,
  output logic                          l3_write_enable_o,
  input  logic [DATA_WIDTH-1:0]         l3_read_data_i,
  input  logic                          l3_stall_i
);

  localparam int IDX_W  = clog2_min1(NUM_REQ);
  localparam int WDOG_W = clog2_min1(TIMEOUT_CYCLES);

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;

  logic                    pickValid;
  logic [NUM_REQ-1:0]      pickOneHot;
  logic [IDX_W-1:0]        pickIdx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pickValid),
    .pick_o  (pickOneHot),
    .idx_o   (pickIdx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wdog_d     = wdog_q;

    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d = ISSUE;
          gnt_d   = pickOneHot;
          idx_d   = pickIdx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pickOneHot[i]) begin
              addr_d  = req_address_i[i*DATA_WIDTH +: DATA_WIDTH];
              wdata_d = req_write_data_i[i*DATA_WIDTH +: DATA_WIDTH];
              we_d    = req_write_enable_i[i];
            end
          end
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      // Completion wins over the watchdog when both happen in the same cycle.
      WAIT: begin
        if (!l3_stall_i) begin
          rsp_data_d = l3_read_data_i;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        gnt_d   = '0;
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wdog_q     <= wdog_d;
    end
  end

  assign gnt_o             = gnt_q;
  assign done_o            = (state_q == RESP) ? gnt_q : '0;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_err_o         = rsp_err_q;
  assign busy_o            = (state_q != IDLE);
  assign l3_valid_o        = (state_q == ISSUE) || (state_q == WAIT);
  assign l3_address_o      = addr_q;
  assign l3_write_data_o   = wdata_q;
  assign l3_write_enable_o = we_q & l3_valid_o;

endmodule

// File: tb/tb_l3_port_arbiter.sv
// Self-checking bench for l3_port_arbiter: vector table, hand-written corner sequences,
// a small stall-programmable L3 model and a scoreboard of expected transactions.
module tb_l3_port_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  reqAddress;
  logic [NR*DW-1:0]  reqWdata;
  logic [NR-1:0]     reqWe;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic [DW-1:0]     rspData;
  logic              rspErr;
  logic              busy;
  logic              l3Valid;
  logic [DW-1:0]     l3Address;
  logic [DW-1:0]     l3Wdata;
  logic              l3We;
  logic [DW-1:0]     l3ReadData;
  logic              l3Stall;

  always #5 clk = ~clk;

  l3_port_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rstN),
    .req_i              (req),
    .req_address_i      (reqAddress),
    .req_write_data_i   (reqWdata),
    .req_write_enable_i (reqWe),
    .gnt_o              (gnt),
    .done_o             (done),
    .rsp_data_o         (rspData),
    .rsp_err_o          (rspErr),
    .busy_o             (busy),
    .l3_valid_o         (l3Valid),
    .l3_address_o       (l3Address),
    .l3_write_data_o    (l3Wdata),
    .l3_write_enable_o  (l3We),
    .l3_read_data_i     (l3ReadData),
    .l3_stall_i         (l3Stall)
  );

  typedef struct {
    logic [NR-1:0] gnt;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [DW-1:0] rsp;
    logic          err;
  } exp_t;

  typedef struct {
    int            who;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdData;
    int            stall;
    int            expLat;
    logic          expErr;
    logic [DW-1:0] expRsp;
  } vec_t;

  exp_t sbQ[$];
  exp_t monE;
  vec_t vecs[6];

  int checks = 0;
  int passes = 0;

  int            stallCfg  = 0;
  bit            useFixed  = 1'b1;
  logic [DW-1:0] fixedData = '0;
  bit            inTxn     = 1'b0;
  int            waitIdx   = 0;

  function automatic logic [DW-1:0] memData(input logic [DW-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // L3 model: stall is ignored in the ISSUE cycle, then held high for stallCfg WAIT cycles.
  always @(negedge clk) begin
    if (l3Valid) begin
      if (!inTxn) begin
        inTxn   = 1'b1;
        waitIdx = 0;
        l3Stall = 1'b0;
      end else begin
        l3Stall = (waitIdx < stallCfg);
        waitIdx++;
      end
      l3ReadData = useFixed ? fixedData : memData(l3Address);
    end else begin
      inTxn   = 1'b0;
      l3Stall = 1'b0;
    end
  end

  // Scoreboard monitor: port contents every valid cycle, response on every done pulse.
  always @(negedge clk) begin
    if (rstN) begin
      if (l3Valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("valid_without_txn", 64'(l3Valid), 64'd0);
        end else begin
          checkOutput("l3_address", 64'(l3Address), 64'(sbQ[0].addr));
          checkOutput("l3_write_data", 64'(l3Wdata), 64'(sbQ[0].wdata));
          checkOutput("gnt_we_busy", 64'({gnt, l3We, busy}), 64'({sbQ[0].gnt, sbQ[0].we, 1'b1}));
        end
      end
      if (done != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("done", 64'(done), 64'(monE.gnt));
          checkOutput("rsp_data", 64'(rspData), 64'(monE.rsp));
          checkOutput("rsp_err", 64'(rspErr), 64'(monE.err));
        end
      end
    end
  end

  task automatic waitDone(input int maxCycles, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done == '0 && lat < maxCycles);
    if (done == '0) checkOutput("done_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic pushExp(input int who, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic we, input logic [DW-1:0] rsp, input logic err);
    exp_t e;
    e.gnt      = '0;
    e.gnt[who] = 1'b1;
    e.addr     = addr;
    e.wdata    = wdata;
    e.we       = we;
    e.rsp      = rsp;
    e.err      = err;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    logic [NR-1:0] mask;
    @(negedge clk);
    mask        = '0;
    mask[v.who] = 1'b1;
    pushExp(v.who, v.addr, v.wdata, v.we, v.expRsp, v.expErr);
    stallCfg  = v.stall;
    useFixed  = 1'b1;
    fixedData = v.rdData;
    for (int r = 0; r < NR; r++) begin
      reqAddress[r*DW +: DW] = (r == v.who) ? v.addr : ~v.addr;
      reqWdata[r*DW +: DW]   = (r == v.who) ? v.wdata : ~v.wdata;
      reqWe[r]               = (r == v.who) ? v.we : ~v.we;
    end
    req = mask;
    waitDone(60, lat);
    checkOutput("latency", 64'(lat), 64'(v.expLat));
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int lat;
    rstN       = 1'b0;
    req        = '0;
    reqAddress = '0;
    reqWdata   = '0;
    reqWe      = '0;
    l3ReadData = '0;
    l3Stall    = 1'b0;

    //         who we    addr           wdata          rdData         stall lat err  rsp
    vecs[0] = '{0, 1'b0, 32'h0000_1040, 32'h0000_0000, 32'hDEAD_BEEF, 2,   5,  1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'hCAFE_0001, 0,   3,  1'b0, 32'hCAFE_0001};
    vecs[2] = '{0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0BAD_F00D, 1,   4,  1'b0, 32'h0BAD_F00D};
    vecs[3] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h7777_0000, 7,   10, 1'b0, 32'h7777_0000};
    vecs[4] = '{0, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'hFFFF_FFFF, 200, 10, 1'b1, 32'h0000_0000};
    vecs[5] = '{1, 1'b0, 32'h0000_4000, 32'h0000_0000, 32'h1111_2222, 0,   3,  1'b0, 32'h1111_2222};

    repeat (3) @(negedge clk);
    checkOutput("reset_ctl", 64'({gnt, done, rspErr, busy, l3Valid, l3We}), 64'd0);
    checkOutput("reset_rsp_data", 64'(rspData), 64'd0);
    checkOutput("reset_l3_addr_wdata", {l3Address, l3Wdata}, 64'd0);
    rstN = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Contention: last grant was requester 1, so order must be 0,1,0,1 every 4 cycles.
    @(negedge clk);
    useFixed = 1'b0;
    stallCfg = 0;
    reqAddress = {32'h0000_0204, 32'h0000_0100};
    reqWdata   = {32'h0000_BBBB, 32'h0000_AAAA};
    reqWe      = '0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) pushExp(0, 32'h0000_0100, 32'h0000_AAAA, 1'b0, memData(32'h0000_0100), 1'b0);
      else            pushExp(1, 32'h0000_0204, 32'h0000_BBBB, 1'b0, memData(32'h0000_0204), 1'b0);
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      waitDone(20, lat);
      checkOutput((i == 0) ? "contention_first_latency" : "contention_spacing", 64'(lat), (i == 0) ? 64'd3 : 64'd4);
    end
    req = '0;

    // Request drop and input change during WAIT must not disturb the latched transaction.
    @(negedge clk);
    useFixed  = 1'b1;
    fixedData = 32'h0BAD_CAFE;
    stallCfg  = 3;
    reqAddress[0 +: DW] = 32'h0000_5000;
    reqWdata[0 +: DW]   = 32'h0000_0055;
    reqWe[0]            = 1'b0;
    pushExp(0, 32'h0000_5000, 32'h0000_0055, 1'b0, 32'h0BAD_CAFE, 1'b0);
    req = 2'b01;
    repeat (3) @(negedge clk);
    req = '0;
    reqAddress[0 +: DW] = 32'hFFFF_0000;
    reqWdata[0 +: DW]   = 32'h9999_9999;
    reqWe[0]            = 1'b1;
    waitDone(30, lat);
    checkOutput("drop_latency", 64'(lat + 3), 64'd6);

    // Mid-transaction reset: outputs clear at once and the transaction never completes.
    @(negedge clk);
    stallCfg = 1000;
    reqAddress[0 +: DW] = 32'h0000_6000;
    reqWe[0]            = 1'b0;
    pushExp(0, 32'h0000_6000, 32'h9999_9999, 1'b0, 32'h0, 1'b0);
    req = 2'b01;
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_busy", 64'({busy, l3Valid}), 64'b11);
    #2;
    sbQ.delete();
    rstN = 1'b0;
    #1;
    checkOutput("midreset_ctl", 64'({gnt, done, rspErr, busy, l3Valid, l3We}), 64'd0);
    checkOutput("midreset_rsp_data", 64'(rspData), 64'd0);
    checkOutput("midreset_l3_addr_wdata", {l3Address, l3Wdata}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("no_done_in_reset", 64'(done), 64'd0);
    end
    stallCfg  = 0;
    fixedData = 32'h5555_AAAA;
    reqAddress = {32'h0000_7100, 32'h0000_7000};
    reqWdata   = {32'h0000_0002, 32'h0000_0001};
    reqWe      = '0;
    pushExp(0, 32'h0000_7000, 32'h0000_0001, 1'b0, 32'h5555_AAAA, 1'b0);
    req  = 2'b11;
    rstN = 1'b1;
    waitDone(20, lat);
    checkOutput("post_reset_latency", 64'(lat), 64'd3);
    req = '0;

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    checkOutput("final_idle", 64'({busy, l3Valid, gnt}), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
